// File: rtl/multdiv_sequencer.sv
// Step sequencer for the shared iterative multiply/divide datapath.
// Moore FSM (IDLE/LOAD/RUN/DONE) with a step counter; a new request aborts any op in flight.
module multdiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic             load_ops,
    output logic             step,
    output logic             last_step,
    output logic             is_div,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             data_resultRDY
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             is_div_q, is_div_d;

    logic             req;
    logic [CNT_W-1:0] last_idx;

    assign req      = ctrl_MULT | ctrl_DIV;
    assign last_idx = is_div_q ? DIV_LAST : MULT_LAST;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;

        if (req) begin
            // Any request restarts from LOAD, aborting an op in flight; multiply wins a tie.
            state_d  = S_LOAD;
            count_d  = '0;
            is_div_d = ~ctrl_MULT;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: begin
                    state_d = S_RUN;
                    count_d = '0;
                end
                S_RUN: begin
                    if (count_q == last_idx) begin
                        state_d = S_DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
        end
    end

    assign load_ops       = (state_q == S_LOAD);
    assign step           = (state_q == S_RUN);
    assign last_step      = (state_q == S_RUN) && (count_q == last_idx);
    assign busy           = (state_q == S_LOAD) || (state_q == S_RUN);
    assign data_resultRDY = (state_q == S_DONE);
    assign is_div         = is_div_q;
    assign count          = count_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: reset, mult/div runs, priority, abort,
// async reset mid-op, back-to-back requests, and a single-step (N=1) instance.
module tb_multdiv_sequencer;

    localparam int CNT_W = 6;
    localparam int N     = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             ctrl_MULT, ctrl_DIV;
    logic             load_ops, step, last_step, is_div, busy, data_resultRDY;
    logic [CNT_W-1:0] count;

    logic             ctrl2_MULT;
    logic             load2, step2, last2, is_div2, busy2, rdy2;
    logic [CNT_W-1:0] count2;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    multdiv_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .load_ops       (load_ops),
        .step           (step),
        .last_step      (last_step),
        .is_div         (is_div),
        .count          (count),
        .busy           (busy),
        .data_resultRDY (data_resultRDY)
    );

    multdiv_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(3), .CNT_W(CNT_W)) dut_n1 (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl2_MULT),
        .ctrl_DIV       (1'b0),
        .load_ops       (load2),
        .step           (step2),
        .last_step      (last2),
        .is_div         (is_div2),
        .count          (count2),
        .busy           (busy2),
        .data_resultRDY (rdy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered in the LOAD cycle right after the request edge E0. Checks N steps,
    // then the DONE cycle, which follows edge E0+N+1.
    task automatic run_op(input logic exp_div, input string name);
        check({name, " load_ops"}, 32'(load_ops), 32'd1);
        check({name, " load busy"}, 32'(busy), 32'd1);
        check({name, " load count"}, 32'(count), 32'd0);
        check({name, " load step"}, 32'(step), 32'd0);
        check({name, " is_div"}, 32'(is_div), 32'(exp_div));
        for (int i = 0; i < N; i++) begin
            tick();
            check($sformatf("%s step %0d", name, i), 32'(step), 32'd1);
            check($sformatf("%s count %0d", name, i), 32'(count), 32'(i));
            check($sformatf("%s last %0d", name, i), 32'(last_step), 32'(i == N - 1));
            check($sformatf("%s rdy %0d", name, i), 32'(data_resultRDY), 32'd0);
            check($sformatf("%s busy %0d", name, i), 32'(busy), 32'd1);
        end
        tick();
        check({name, " done rdy"}, 32'(data_resultRDY), 32'd1);
        check({name, " done busy"}, 32'(busy), 32'd0);
        check({name, " done step"}, 32'(step), 32'd0);
        check({name, " done load"}, 32'(load_ops), 32'd0);
        check({name, " done count"}, 32'(count), 32'd0);
        check({name, " done is_div"}, 32'(is_div), 32'(exp_div));
    endtask

    initial begin
        reset      = 1'b0;
        ctrl_MULT  = 1'b0;
        ctrl_DIV   = 1'b0;
        ctrl2_MULT = 1'b0;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst rdy", 32'(data_resultRDY), 32'd0);
        check("rst load", 32'(load_ops), 32'd0);
        check("rst step", 32'(step), 32'd0);
        check("rst last", 32'(last_step), 32'd0);
        check("rst is_div", 32'(is_div), 32'd0);
        reset = 1'b1;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        // Plain multiply
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        run_op(1'b0, "mult");
        tick();
        check("mult idle rdy", 32'(data_resultRDY), 32'd0);
        check("mult idle busy", 32'(busy), 32'd0);

        // Both requests together: multiply wins
        ctrl_MULT = 1'b1;
        ctrl_DIV  = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        run_op(1'b0, "both");
        tick();

        // Divide aborted at count 10 by a multiply
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        check("abort div load", 32'(load_ops), 32'd1);
        check("abort div is_div", 32'(is_div), 32'd1);
        repeat (11) tick();
        check("abort at count", 32'(count), 32'd10);
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        run_op(1'b0, "abort mult");
        tick();
        check("abort idle rdy", 32'(data_resultRDY), 32'd0);

        // Async reset mid-divide at count 20
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        repeat (21) tick();
        check("mid rst count before", 32'(count), 32'd20);
        check("mid rst is_div before", 32'(is_div), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst count", 32'(count), 32'd0);
        check("mid rst step", 32'(step), 32'd0);
        check("mid rst is_div", 32'(is_div), 32'd0);
        tick();
        check("mid rst rdy a", 32'(data_resultRDY), 32'd0);
        tick();
        check("mid rst rdy b", 32'(data_resultRDY), 32'd0);
        reset = 1'b1;
        tick();
        check("post rst rdy", 32'(data_resultRDY), 32'd0);
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        run_op(1'b1, "div after rst");
        tick();

        // Back-to-back: request held in the DONE cycle
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        run_op(1'b1, "b2b first");
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        run_op(1'b1, "b2b second");
        tick();
        check("b2b idle rdy", 32'(data_resultRDY), 32'd0);
        check("b2b is_div hold", 32'(is_div), 32'd1);
        repeat (3) tick();
        check("is_div hold later", 32'(is_div), 32'd1);

        // Single-step instance (MULT_CYCLES = 1)
        ctrl2_MULT = 1'b1;
        tick();
        ctrl2_MULT = 1'b0;
        check("n1 load", 32'(load2), 32'd1);
        check("n1 load busy", 32'(busy2), 32'd1);
        tick();
        check("n1 step", 32'(step2), 32'd1);
        check("n1 last", 32'(last2), 32'd1);
        check("n1 count", 32'(count2), 32'd0);
        check("n1 is_div", 32'(is_div2), 32'd0);
        tick();
        check("n1 rdy", 32'(rdy2), 32'd1);
        check("n1 done busy", 32'(busy2), 32'd0);
        tick();
        check("n1 idle rdy", 32'(rdy2), 32'd0);
        check("n1 idle busy", 32'(busy2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
